// File: rtl/ascon_aead128_driver_pkg.sv
// Shared types and sizing for the ASCON-AEAD128 message driver.
package ascon_aead128_driver_pkg;

   localparam int BLK_W          = 128;
   localparam int CNT_W          = 8;
   localparam int OUT_FIFO_DEPTH = 2;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      AD_PH,
      DB_PH,
      TAG_WAIT
   } drv_state_t;

   // A message needs at least one DB block after AD, or two DB blocks when there is no AD.
   function automatic logic desc_legal(input logic [CNT_W-1:0] ad_cnt,
                                       input logic [CNT_W-1:0] db_cnt);
      return ((ad_cnt != '0) && (db_cnt != '0)) ||
             ((ad_cnt == '0) && (db_cnt >= CNT_W'(2)));
   endfunction

endpackage

// File: rtl/ascon_blk_fifo.sv
// Small show-ahead block FIFO; head entry is visible on dout_o whenever not empty.
module ascon_blk_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 128,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (count_q != CW'(DEPTH));

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ascon_aead128_driver.sv
// Sequences one AEAD message through an ASCON-128 core: AD blocks, DB blocks, then the tag.
module ascon_aead128_driver
   import ascon_aead128_driver_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [CNT_W-1:0] cmd_ad_cnt_i,
   input  logic [CNT_W-1:0] cmd_db_cnt_i,
   input  logic             ad_valid_i,
   output logic             ad_ready_o,
   input  logic [BLK_W-1:0] ad_data_i,
   input  logic             db_valid_i,
   output logic             db_ready_o,
   input  logic [BLK_W-1:0] db_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [BLK_W-1:0] out_data_o,
   output logic             tag_valid_o,
   input  logic             tag_ready_i,
   output logic [BLK_W-1:0] tag_data_o,
   output logic             core_start_o,
   output logic             core_valid_ad_o,
   output logic             core_valid_db_in_o,
   output logic [BLK_W-1:0] core_din_o,
   input  logic             core_ready_i,
   input  logic             core_valid_db_out_i,
   input  logic             core_valid_tag_i,
   input  logic [BLK_W-1:0] core_dout_i,
   output logic             done_o,
   output logic             err_o
);

   localparam int FCW = $clog2(OUT_FIFO_DEPTH + 1);

   drv_state_t       state_q, state_d;
   logic [CNT_W-1:0] ad_left_q, db_left_q;
   logic [FCW-1:0]   inflight_q;
   logic [FCW-1:0]   fifo_count;
   logic             fifo_empty, fifo_full;
   logic             issued_q, start_q, vad_q, vdb_q;
   logic [BLK_W-1:0] din_q, tag_q;
   logic             tag_valid_q, tag_acc_q, done_q, err_q;
   logic             issue_ad, issue_db, cmd_legal, out_room, tag_fire, finish;

   assign cmd_legal = desc_legal(cmd_ad_cnt_i, cmd_db_cnt_i);
   assign tag_fire  = tag_valid_q && tag_ready_i;
   assign finish    = (state_q == TAG_WAIT) && tag_acc_q && fifo_empty;
   // Buffered plus outstanding DB results must always fit in the out FIFO.
   assign out_room  = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (FCW + 1)'(OUT_FIFO_DEPTH);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decision.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (cmd_valid_i && cmd_legal) state_d = LAUNCH;
         LAUNCH:   if (core_ready_i) state_d = (ad_left_q != '0) ? AD_PH : DB_PH;
         AD_PH:    if (issue_ad && (ad_left_q == CNT_W'(1))) state_d = DB_PH;
         DB_PH:    if (issue_db && (db_left_q == CNT_W'(1))) state_d = TAG_WAIT;
         TAG_WAIT: if (finish) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Handshake outputs and issue decisions; at most one issue every other cycle.
   always_comb begin
      cmd_ready_o = (state_q == IDLE);
      issue_ad    = (state_q == AD_PH) && core_ready_i && ad_valid_i && !issued_q &&
                    (ad_left_q != '0);
      issue_db    = (state_q == DB_PH) && core_ready_i && db_valid_i && !issued_q &&
                    (db_left_q != '0) && out_room;
      ad_ready_o  = issue_ad;
      db_ready_o  = issue_db;
   end

   // Core-facing pulses, block counters and the start strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vad_q     <= 1'b0;
         vdb_q     <= 1'b0;
         issued_q  <= 1'b0;
         din_q     <= '0;
         ad_left_q <= '0;
         db_left_q <= '0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         vad_q    <= issue_ad;
         vdb_q    <= issue_db;
         issued_q <= issue_ad || issue_db;
         err_q    <= cmd_ready_o && cmd_valid_i && !cmd_legal;
         if (issue_ad)      din_q <= ad_data_i;
         else if (issue_db) din_q <= db_data_i;
         if (cmd_ready_o && cmd_valid_i) begin
            ad_left_q <= cmd_ad_cnt_i;
            db_left_q <= cmd_db_cnt_i;
         end else begin
            if (issue_ad) ad_left_q <= ad_left_q - CNT_W'(1);
            if (issue_db) db_left_q <= db_left_q - CNT_W'(1);
         end
         // Start drops together with the pulse carrying the final DB block.
         if (cmd_ready_o && cmd_valid_i && cmd_legal)       start_q <= 1'b1;
         else if (issue_db && (db_left_q == CNT_W'(1)))    start_q <= 1'b0;
      end
   end

   // In-flight DB tracking, tag holding register and completion pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_q  <= '0;
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
         tag_acc_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         if (issue_db && !core_valid_db_out_i) begin
            inflight_q <= inflight_q + FCW'(1);
         end else if (!issue_db && core_valid_db_out_i && (inflight_q != '0)) begin
            inflight_q <= inflight_q - FCW'(1);
         end
         if (core_valid_tag_i) begin
            tag_q       <= core_dout_i;
            tag_valid_q <= 1'b1;
         end else if (tag_fire) begin
            tag_valid_q <= 1'b0;
         end
         if (finish)        tag_acc_q <= 1'b0;
         else if (tag_fire) tag_acc_q <= 1'b1;
         done_q <= finish;
      end
   end

   ascon_blk_fifo #(
      .DEPTH (OUT_FIFO_DEPTH),
      .WIDTH (BLK_W),
      .CW    (FCW)
   ) u_out_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (core_valid_db_out_i),
      .din_i   (core_dout_i),
      .pop_i   (out_valid_o && out_ready_i),
      .dout_o  (out_data_o),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   // The credit check above makes a result beat into a full FIFO impossible.
   assert property (@(posedge clk) disable iff (!rst_n) core_valid_db_out_i |-> !fifo_full);

   assign out_valid_o        = !fifo_empty;
   assign tag_valid_o        = tag_valid_q;
   assign tag_data_o         = tag_q;
   assign core_start_o       = start_q;
   assign core_valid_ad_o    = vad_q;
   assign core_valid_db_in_o = vdb_q;
   assign core_din_o         = din_q;
   assign done_o             = done_q;
   assign err_o              = err_q;

endmodule

// File: tb/tb_ascon_aead128_driver.sv
// Directed bench for ascon_aead128_driver with a behavioural core (fixed latency XOR transform).
module tb_ascon_aead128_driver;
   import ascon_aead128_driver_pkg::*;

   localparam logic [127:0] DBK = {16{8'h5A}};
   localparam logic [127:0] TK  = {16{8'hC3}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         cmd_valid, cmd_ready;
   logic [7:0]   cmd_ad_cnt, cmd_db_cnt;
   logic         ad_valid, ad_ready, db_valid, db_ready;
   logic [127:0] ad_data, db_data;
   logic         out_valid, out_ready, tag_valid, tag_ready;
   logic [127:0] out_data, tag_data;
   logic         core_start, core_valid_ad, core_valid_db_in;
   logic [127:0] core_din;
   logic         core_ready, core_valid_db_out, core_valid_tag;
   logic [127:0] core_dout;
   logic         done, err;

   ascon_aead128_driver dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_ad_cnt_i(cmd_ad_cnt), .cmd_db_cnt_i(cmd_db_cnt),
      .ad_valid_i(ad_valid), .ad_ready_o(ad_ready), .ad_data_i(ad_data),
      .db_valid_i(db_valid), .db_ready_o(db_ready), .db_data_i(db_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .tag_valid_o(tag_valid), .tag_ready_i(tag_ready), .tag_data_o(tag_data),
      .core_start_o(core_start), .core_valid_ad_o(core_valid_ad),
      .core_valid_db_in_o(core_valid_db_in), .core_din_o(core_din),
      .core_ready_i(core_ready), .core_valid_db_out_i(core_valid_db_out),
      .core_valid_tag_i(core_valid_tag), .core_dout_i(core_dout),
      .done_o(done), .err_o(err)
   );

   // Behavioural core: DB result 3 cycles after its input pulse, tag 6 cycles after the last DB.
   logic [1:0]   pv;
   logic [127:0] p0, p1, acc;
   logic         start_prev;
   int           tmr;
   always @(posedge clk) begin
      if (!rst_n) begin
         pv <= '0; p0 <= '0; p1 <= '0; acc <= '0; start_prev <= 1'b0; tmr <= 0;
         core_valid_db_out <= 1'b0; core_valid_tag <= 1'b0; core_dout <= '0;
      end else begin
         start_prev        <= core_start;
         pv                <= {pv[0], core_valid_db_in};
         p0                <= core_din ^ DBK;
         p1                <= p0;
         core_valid_db_out <= pv[1];
         core_valid_tag    <= (tmr == 1);
         if (pv[1])         core_dout <= p1;
         else if (tmr == 1) core_dout <= acc ^ TK;
         if (core_valid_db_in && !core_start) tmr <= 5;
         else if (tmr != 0)                   tmr <= tmr - 1;
         if (core_start && !start_prev)              acc <= '0;
         else if (core_valid_ad || core_valid_db_in) acc <= acc ^ core_din;
      end
   end

   int n_chk = 0, n_pass = 0;
   logic [127:0] ad_mem [8];
   logic [127:0] db_mem [8];
   logic [127:0] exp_q [$];
   logic [127:0] exp_tag;
   int ad_n, db_n, ad_idx, db_idx, cur_db;
   int n_ad, n_db, n_out, n_tag, n_done, n_err, n_start;
   int cyc = 0, last_issue = -10;
   int viol_both = 0, viol_space = 0, viol_credit = 0, viol_extra = 0;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive_src();
      ad_valid = (ad_idx < ad_n);
      ad_data  = (ad_idx < ad_n) ? ad_mem[ad_idx] : '0;
      db_valid = (db_idx < db_n);
      db_data  = (db_idx < db_n) ? db_mem[db_idx] : '0;
   endtask

   // One clock: observe at the falling edge, advance sources just after the rising edge.
   task automatic step();
      bit ad_hs, db_hs;
      @(negedge clk);
      ad_hs = ad_valid && ad_ready;
      db_hs = db_valid && db_ready;
      if (core_valid_ad && core_valid_db_in) viol_both++;
      if (core_valid_ad || core_valid_db_in) begin
         if (cyc - last_issue < 2) viol_space++;
         last_issue = cyc;
      end
      if (core_valid_ad) n_ad++;
      if (core_valid_db_in) begin
         chk("start_at_db_pulse", {127'd0, core_start}, {127'd0, (n_db + 1 < cur_db)});
         n_db++;
      end
      if (n_db - n_out > 2) viol_credit++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) viol_extra++;
         else chk("out_data", out_data, exp_q.pop_front());
         n_out++;
      end
      if (tag_valid && tag_ready) begin
         chk("tag_data", tag_data, exp_tag);
         n_tag++;
      end
      if (done)       n_done++;
      if (err)        n_err++;
      if (core_start) n_start++;
      @(posedge clk);
      #1;
      cyc++;
      if (ad_hs) ad_idx++;
      if (db_hs) db_idx++;
      drive_src();
   endtask

   task automatic load_msg(int ad, int db, int id);
      exp_q.delete();
      exp_tag = TK;
      for (int i = 0; i < ad; i++) begin
         ad_mem[i] = {4{32'h0A00_0000 + 32'(id * 16 + i)}};
         exp_tag   = exp_tag ^ ad_mem[i];
      end
      for (int i = 0; i < db; i++) begin
         db_mem[i] = {4{32'h0D00_0000 + 32'(id * 16 + i)}};
         exp_tag   = exp_tag ^ db_mem[i];
         exp_q.push_back(db_mem[i] ^ DBK);
      end
      ad_n = ad; db_n = db; ad_idx = 0; db_idx = 0; cur_db = db;
      n_ad = 0; n_db = 0; n_out = 0; n_tag = 0; n_done = 0; n_err = 0; n_start = 0;
      drive_src();
      cmd_ad_cnt = 8'(ad);
      cmd_db_cnt = 8'(db);
      cmd_valid  = 1'b1;
      chk("cmd_ready_idle", {127'd0, cmd_ready}, 128'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(string nm, int budget);
      for (int k = 0; k < budget && n_done == 0; k++) step();
      chk({nm, "_done_seen"}, 128'(n_done), 128'd1);
      step();
      step();
   endtask

   task automatic finish_msg(string nm, int ad, int db);
      chk({nm, "_ad_pulses"}, 128'(n_ad), 128'(ad));
      chk({nm, "_db_pulses"}, 128'(n_db), 128'(db));
      chk({nm, "_outputs"}, 128'(n_out), 128'(db));
      chk({nm, "_tags"}, 128'(n_tag), 128'd1);
      chk({nm, "_done_once"}, 128'(n_done), 128'd1);
      chk({nm, "_start_low"}, {127'd0, core_start}, 128'd0);
      chk({nm, "_idle"}, {127'd0, cmd_ready}, 128'd1);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_ad_cnt = '0; cmd_db_cnt = '0;
      ad_n = 0; db_n = 0; ad_idx = 0; db_idx = 0; cur_db = 0;
      drive_src();
      out_ready = 1'b1; tag_ready = 1'b1; core_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
      chk("rst_core_start", {127'd0, core_start}, 128'd0);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_tag_valid", {127'd0, tag_valid}, 128'd0);
      chk("rst_done_err", {126'd0, done, err}, 128'd0);
      rst_n = 1'b1;

      // ad=1, db=1
      load_msg(1, 1, 1);
      wait_done("m1", 80);
      finish_msg("m1", 1, 1);

      // ad=0, db=3
      load_msg(0, 3, 2);
      wait_done("m2", 100);
      finish_msg("m2", 0, 3);

      // ad=0, db=1 is illegal
      load_msg(0, 1, 3);
      step(); step(); step();
      chk("m3_err_pulse", 128'(n_err), 128'd1);
      chk("m3_no_start", 128'(n_start), 128'd0);
      chk("m3_cmd_ready", {127'd0, cmd_ready}, 128'd1);
      chk("m3_no_db", 128'(n_db), 128'd0);

      // ad=2, db=4 with the sink stalled
      out_ready = 1'b0;
      load_msg(2, 4, 4);
      repeat (40) step();
      chk("m4_db_stalled", 128'(n_db), 128'd2);
      chk("m4_out_valid", {127'd0, out_valid}, 128'd1);
      chk("m4_no_done", 128'(n_done), 128'd0);
      out_ready = 1'b1;
      wait_done("m4", 150);
      finish_msg("m4", 2, 4);

      // LAUNCH waits for core_ready
      core_ready = 1'b0;
      load_msg(1, 2, 5);
      repeat (4) step();
      chk("m5_start_held", {127'd0, core_start}, 128'd1);
      chk("m5_no_ad", 128'(n_ad), 128'd0);
      chk("m5_busy", {127'd0, cmd_ready}, 128'd0);
      core_ready = 1'b1;
      wait_done("m5", 100);
      finish_msg("m5", 1, 2);

      // reset during DB_PH of ad=1, db=3
      load_msg(1, 3, 6);
      for (int k = 0; k < 60 && n_db < 1; k++) step();
      chk("m6_in_db", 128'(n_db), 128'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("m6_cmd_ready", {127'd0, cmd_ready}, 128'd1);
      chk("m6_core_pulses", {125'd0, core_start, core_valid_ad, core_valid_db_in}, 128'd0);
      chk("m6_out_tag", {126'd0, out_valid, tag_valid}, 128'd0);
      chk("m6_done_err", {126'd0, done, err}, 128'd0);
      rst_n = 1'b1;
      last_issue = cyc - 10;

      load_msg(1, 1, 7);
      wait_done("m7", 80);
      finish_msg("m7", 1, 1);

      chk("ad_db_exclusive", 128'(viol_both), 128'd0);
      chk("issue_spacing", 128'(viol_space), 128'd0);
      chk("out_credit", 128'(viol_credit), 128'd0);
      chk("out_extra", 128'(viol_extra), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ascon_aead128_driver.md
ASCON_AEAD128_DRIVER -- requirements
Module: ascon_aead128_driver

Interface
REQ-001 clk  in  1  clock; rst_n  in  1  reset; one clock, reset synchronous and active-low.
REQ-002 cmd_valid/cmd_ready  in/out  1/1  message descriptor handshake; cmd_ad_cnt, cmd_db_cnt  in  8/8  AD and DB 128-bit block counts.
REQ-003 ad_valid/ad_ready  in/out  1/1, ad_data  in  128  associated-data source stream.
REQ-004 db_valid/db_ready  in/out  1/1, db_data  in  128  plaintext/ciphertext source stream.
REQ-005 out_valid/out_ready  out/in  1/1, out_data  out  128  processed DB sink stream.
REQ-006 tag_valid/tag_ready  out/in  1/1, tag_data  out  128  tag sink.
REQ-007 core_start, core_valid_ad, core_valid_db_in  out  1 each; core_din  out  128  drive core inputs.
REQ-008 core_ready, core_valid_db_out, core_valid_tag  in  1 each; core_dout  in  128  core outputs.
REQ-009 done  out  1  one-cycle pulse after tag accepted; err  out  1  one-cycle pulse on illegal descriptor.

Function
REQ-010 States SHALL be IDLE, LAUNCH, AD_PH, DB_PH, TAG_WAIT.
REQ-011 IDLE: cmd_ready=1; on cmd_valid latch counts; legal iff (ad>=1 and db>=1) or (ad=0 and db>=2); legal -> LAUNCH, illegal -> err pulse, stay IDLE.
REQ-012 LAUNCH: core_start=1; on first cycle core_ready=1 -> AD_PH if ad_left>0 else DB_PH.
REQ-013 core_start SHALL stay 1 from LAUNCH until the cycle core_valid_db_in carries the last DB block, in which core_start=0, and SHALL stay 0 until next LAUNCH.
REQ-014 Issue: a block is issued when core_ready=1, source valid, no issue in the previous cycle; core_valid_* registered, pulsed exactly one cycle, core_din registered with it; source ready pulsed in the issue-decision cycle.
REQ-015 AD_PH issues ad blocks, decrements ad_left; at ad_left=0 -> DB_PH; core_valid_ad and core_valid_db_in never both 1.
REQ-016 DB_PH issues DB only when out-FIFO count + in-flight DB < 2; decrements db_left; after last DB -> TAG_WAIT.
REQ-017 core_valid_db_out=1 SHALL push core_dout into 2-entry out FIFO; out_valid = FIFO not empty; pop on out_valid&out_ready; simultaneous push/pop keeps count.
REQ-018 core_valid_tag=1 SHALL load tag register, tag_valid=1 until tag_ready; then done pulse, -> IDLE.
REQ-019 TAG_WAIT -> IDLE only after tag accepted and out FIFO empty.
REQ-020 cmd_ready=0 outside IDLE; counts 8-bit, never wrap (decrement only when >0).
REQ-021 core_valid_db_out with full FIFO SHALL not occur by construction; assertion flags it.

Reset
REQ-022 rst_n=0 at clk edge: state IDLE, counters 0, FIFO empty, all outputs 0 except cmd_ready=1 next cycle.
REQ-023 Reset mid-message SHALL abandon message, drop buffered data; core must be reset in the same cycle by system.

Structure
REQ-024 Shared package holds drv_state_t enum, BLK_W=128, CNT_W=8, OUT_FIFO_DEPTH=2.
REQ-025 Out FIFO SHALL be sub-module ascon_blk_fifo (parameter depth, width).

Verification
REQ-026 ad=1, db=1: start high 1 AD + 1 DB; core_start=0 with DB pulse; 1 out block, tag, done.
REQ-027 ad=0, db=3: no core_valid_ad; core_start low only on 3rd DB; 3 outputs in order.
REQ-028 ad=0, db=1 -> err pulse, no core_start, cmd_ready stays 1.
REQ-029 ad=2, db=4, out_ready=0: issues stop at 2 buffered; resume after pops; no loss.
REQ-030 core_ready held 1 for 3 cycles: issues spaced >=2 cycles, single-cycle pulses.
REQ-031 rst_n=0 during DB_PH of ad=1, db=3: next cycle IDLE, outputs 0, next message correct.
